// File: rtl/lcd_bg_fetcher.sv
// lcd_bg_fetcher
//   Background tile fetcher for the LCD pipeline. For every scanline it walks
//   NUM_TILES tiles: one tile-map byte read, then the two 2bpp bytes of the
//   selected tile row. Each tile row is offered to the pixel FIFO as a
//   16-bit word over a valid/ready handshake. Read-only master on the LCD RAM
//   bus.
//
//   Ports:
//     I_CLK, I_RESET_L        clock, async active-low reset
//     I_START                 one-cycle pulse, begins a line (ignored unless idle)
//     I_LY/I_SCX/I_SCY        scanline and scroll registers, latched on start
//     I_MAP_SEL, I_TILE_SEL   map base / tile-data addressing mode
//     O_LCDRAM_ADDR           VRAM byte address
//     IO_LCDRAM_DATA          VRAM data bus, never driven by this block
//     O_LCDRAM_WE_L/RE_L      active-low write (always high) / read strobes
//     O_PIX_DATA/VALID        {hi,lo} tile row toward the pixel FIFO
//     I_PIX_READY             FIFO accepts O_PIX_DATA
//     O_BUSY, O_DONE          line in progress / end-of-line pulse
module lcd_bg_fetcher #(
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned NUM_TILES = 21
) (
    input  logic            I_CLK,
    input  logic            I_RESET_L,
    input  logic            I_START,
    input  logic [7:0]      I_LY,
    input  logic [7:0]      I_SCX,
    input  logic [7:0]      I_SCY,
    input  logic            I_MAP_SEL,
    input  logic            I_TILE_SEL,
    output logic [15:0]     O_LCDRAM_ADDR,
    inout  wire logic [7:0] IO_LCDRAM_DATA,
    output logic            O_LCDRAM_WE_L,
    output logic            O_LCDRAM_RE_L,
    output logic [15:0]     O_PIX_DATA,
    output logic            O_PIX_VALID,
    input  logic            I_PIX_READY,
    output logic            O_BUSY,
    output logic            O_DONE
);

    typedef enum logic [2:0] {IDLE, MAP_RD, LO_RD, HI_RD, PUSH, DONE} state_t;

    localparam logic [1:0] RD_LAST   = 2'(READ_LAT - 1);
    localparam logic [4:0] TILE_LAST = 5'(NUM_TILES - 1);

    state_t     state;
    logic [7:0] y_q;          // (LY + SCY) mod 256, latched at start
    logic [4:0] scx_q;        // coarse scroll, SCX[7:3]
    logic       map_sel_q;
    logic       tile_sel_q;
    logic [4:0] n;            // tile counter within the line
    logic [1:0] rd_cnt;       // cycles spent in the current read
    logic [7:0] lo_q;

    logic [7:0] start_y;
    logic       unused_scx_fine;

    assign start_y         = I_LY + I_SCY;
    assign unused_scx_fine = ^I_SCX[2:0];

    assign IO_LCDRAM_DATA = 'z;
    assign O_LCDRAM_WE_L  = 1'b1;

    // tx wraps at 32 through the 5-bit width of the tile column.
    function automatic logic [15:0] map_addr(input logic sel, input logic [7:0] y,
                                             input logic [4:0] tx);
        return (sel ? 16'h9C00 : 16'h9800) + {6'd0, y[7:3], tx};
    endfunction

    // Signed mode sign-extends the index before scaling, so 0x80..0xFF land
    // below the 0x9000 base.
    function automatic logic [15:0] tile_addr(input logic sel, input logic [7:0] idx,
                                              input logic [2:0] fy);
        logic [15:0] base;
        logic [15:0] off;
        base = sel ? 16'h8000 : 16'h9000;
        off  = sel ? {4'd0, idx, 4'd0} : {{4{idx[7]}}, idx, 4'd0};
        return base + off + {12'd0, fy, 1'b0};
    endfunction

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state         <= IDLE;
            O_LCDRAM_ADDR <= '0;
            O_LCDRAM_RE_L <= 1'b1;
            O_PIX_DATA    <= '0;
            O_PIX_VALID   <= 1'b0;
            O_BUSY        <= 1'b0;
            O_DONE        <= 1'b0;
            n             <= '0;
            rd_cnt        <= '0;
            y_q           <= '0;
            scx_q         <= '0;
            map_sel_q     <= 1'b0;
            tile_sel_q    <= 1'b0;
            lo_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_START) begin
                        y_q           <= start_y;
                        scx_q         <= I_SCX[7:3];
                        map_sel_q     <= I_MAP_SEL;
                        tile_sel_q    <= I_TILE_SEL;
                        n             <= '0;
                        rd_cnt        <= '0;
                        O_LCDRAM_ADDR <= map_addr(I_MAP_SEL, start_y, I_SCX[7:3]);
                        O_LCDRAM_RE_L <= 1'b0;
                        O_BUSY        <= 1'b1;
                        state         <= MAP_RD;
                    end
                end
                MAP_RD, LO_RD, HI_RD: begin
                    // RE_L stays low across consecutive reads; only the address
                    // steps at each state boundary.
                    if (rd_cnt == RD_LAST) begin
                        rd_cnt <= '0;
                        if (state == MAP_RD) begin
                            O_LCDRAM_ADDR <= tile_addr(tile_sel_q, IO_LCDRAM_DATA, y_q[2:0]);
                            state         <= LO_RD;
                        end else if (state == LO_RD) begin
                            lo_q          <= IO_LCDRAM_DATA;
                            O_LCDRAM_ADDR <= O_LCDRAM_ADDR + 16'd1;
                            state         <= HI_RD;
                        end else begin
                            O_PIX_DATA    <= {IO_LCDRAM_DATA, lo_q};
                            O_PIX_VALID   <= 1'b1;
                            O_LCDRAM_RE_L <= 1'b1;
                            state         <= PUSH;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                PUSH: begin
                    if (I_PIX_READY) begin
                        O_PIX_VALID <= 1'b0;
                        if (n == TILE_LAST) begin
                            O_DONE <= 1'b1;
                            state  <= DONE;
                        end else begin
                            n             <= n + 5'd1;
                            O_LCDRAM_ADDR <= map_addr(map_sel_q, y_q, scx_q + n + 5'd1);
                            O_LCDRAM_RE_L <= 1'b0;
                            state         <= MAP_RD;
                        end
                    end
                end
                DONE: begin
                    O_DONE <= 1'b0;
                    O_BUSY <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bg_fetcher.sv
// Testbench for lcd_bg_fetcher: a READ_LAT=2 instance under test plus a
// READ_LAT=1 instance driven with the same line requests. A VRAM array
// answers reads; a line-level reference model derives the expected read
// address sequence and tile rows from the scroll/map/tile rules.
module tb_lcd_bg_fetcher;

    localparam int L  = 2;
    localparam int L1 = 1;
    localparam int NT = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, map_sel, tile_sel, ready;
    logic [7:0]  ly, scx, scy;
    logic [15:0] addr, pix, addr1, pix1;
    logic        we_l, re_l, valid, busy, done;
    logic        we_l1, re_l1, valid1, busy1, done1;
    wire  [7:0]  bus, bus1;
    logic [7:0]  vram [0:65535];

    assign bus  = vram[addr];
    assign bus1 = vram[addr1];

    lcd_bg_fetcher #(.READ_LAT(L), .NUM_TILES(NT)) dut (
        .I_CLK(clk), .I_RESET_L(rst_n), .I_START(start),
        .I_LY(ly), .I_SCX(scx), .I_SCY(scy),
        .I_MAP_SEL(map_sel), .I_TILE_SEL(tile_sel),
        .O_LCDRAM_ADDR(addr), .IO_LCDRAM_DATA(bus),
        .O_LCDRAM_WE_L(we_l), .O_LCDRAM_RE_L(re_l),
        .O_PIX_DATA(pix), .O_PIX_VALID(valid), .I_PIX_READY(ready),
        .O_BUSY(busy), .O_DONE(done)
    );

    lcd_bg_fetcher #(.READ_LAT(L1), .NUM_TILES(NT)) dut1 (
        .I_CLK(clk), .I_RESET_L(rst_n), .I_START(start),
        .I_LY(ly), .I_SCX(scx), .I_SCY(scy),
        .I_MAP_SEL(map_sel), .I_TILE_SEL(tile_sel),
        .O_LCDRAM_ADDR(addr1), .IO_LCDRAM_DATA(bus1),
        .O_LCDRAM_WE_L(we_l1), .O_LCDRAM_RE_L(re_l1),
        .O_PIX_DATA(pix1), .O_PIX_VALID(valid1), .I_PIX_READY(1'b1),
        .O_BUSY(busy1), .O_DONE(done1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_addr[$];
    logic [15:0] exp_pix[$];

    task automatic build_expect(input logic [7:0] ly_, input logic [7:0] scx_,
                                input logic [7:0] scy_, input logic ms, input logic ts);
        int y, fy, tx, ma, idx, ta;
        exp_addr.delete();
        exp_pix.delete();
        y  = (int'(ly_) + int'(scy_)) % 256;
        fy = y % 8;
        for (int k = 0; k < NT; k++) begin
            tx  = (int'(scx_) / 8 + k) % 32;
            ma  = (ms ? 'h9C00 : 'h9800) + (y / 8) * 32 + tx;
            idx = int'(vram[ma]);
            if (ts) ta = 'h8000 + idx * 16 + fy * 2;
            else    ta = 'h9000 + ((idx >= 128) ? idx - 256 : idx) * 16 + fy * 2;
            exp_addr.push_back(16'(ma));
            exp_addr.push_back(16'(ta));
            exp_addr.push_back(16'(ta + 1));
            exp_pix.push_back({vram[ta + 1], vram[ta]});
        end
    endtask

    // ---------------- monitors ----------------
    logic [15:0] got_addr[$];
    logic [15:0] got_pix[$];
    logic [15:0] got_pix1[$];
    int          cyc = 0;
    int          run_len, first_rd, done_cyc, first_rd1, done_cyc1, reads1, first_push_len;
    bit          mon_en = 0;
    bit          done_seen, done1_seen, prev_low, prev_low1, prev_valid, prev_ready;
    logic [15:0] prev_addr, prev_addr1, prev_pix;
    int          rmode = 0;
    int          stall_left = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            check("we_l_high", we_l, 1'b1);
            // one entry per read: a read is a run of RE_L-low cycles on one address
            if (!re_l) begin
                if (prev_low && addr == prev_addr) run_len++;
                else begin
                    if (prev_low) check("read_len", run_len, L);
                    got_addr.push_back(addr);
                    if (got_addr.size() == 1) first_rd = cyc;
                    run_len = 1;
                end
            end else if (prev_low) check("read_len", run_len, L);
            prev_low  = !re_l;
            prev_addr = addr;

            if (valid) begin
                check("no_read_in_push", re_l, 1'b1);
                if (prev_valid && !prev_ready) check("hold_data", pix, prev_pix);
                if (got_pix.size() == 0) first_push_len++;
                if (ready) got_pix.push_back(pix);
            end else if (prev_valid && !prev_ready) check("hold_valid", valid, 1'b1);
            prev_valid = valid;
            prev_ready = ready;
            prev_pix   = pix;
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                check("busy_in_done", busy, 1'b1);
            end

            if (!re_l1) begin
                if (prev_low1) check("l1_one_cycle_read", addr1 != prev_addr1, 1'b1);
                reads1++;
                if (reads1 == 1) first_rd1 = cyc;
            end
            prev_low1  = !re_l1;
            prev_addr1 = addr1;
            if (valid1) got_pix1.push_back(pix1);
            if (done1) begin
                done1_seen = 1;
                done_cyc1  = cyc;
            end
        end else begin
            prev_low   = 0;
            prev_low1  = 0;
            prev_valid = 0;
            prev_ready = 1;
        end
    end

    // READY driver: 0 = always high, 1 = random, 2 = low for the first 5 PUSH cycles
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: ready = 1'b1;
            1: ready = 1'($urandom_range(0, 1));
            default: begin
                if (valid && stall_left > 0) begin
                    ready = 1'b0;
                    stall_left--;
                end else ready = 1'b1;
            end
        endcase
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0]  ly, scx, scy;
        logic        ms, ts;
        int          rm;
        bit          dbl;
        bit          fixed;
        logic [15:0] map0, map1, lo0;
        bit          has_pix;
        logic [15:0] pix0;
        int          cycles;
    } vec_t;

    task automatic clear_mon();
        got_addr.delete();
        got_pix.delete();
        got_pix1.delete();
        done_seen = 0; done1_seen = 0;
        reads1 = 0; first_push_len = 0; run_len = 0;
        first_rd = 0; done_cyc = 0; first_rd1 = 0; done_cyc1 = 0;
    endtask

    task automatic run_line(input vec_t v);
        ly = v.ly; scx = v.scx; scy = v.scy; map_sel = v.ms; tile_sel = v.ts;
        build_expect(v.ly, v.scx, v.scy, v.ms, v.ts);
        clear_mon();
        stall_left = 5;
        rmode      = v.rm;
        mon_en     = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3000 && !(done_seen && done1_seen); i++) begin
            @(posedge clk); #2;
            if (v.dbl && i == 40) begin
                start    = 1'b1;
                ly       = ly + 8'd77;
                scx      = scx ^ 8'hA5;
                scy      = scy + 8'd3;
                tile_sel = ~tile_sel;
            end else if (v.dbl && i == 41) start = 1'b0;
        end
        check("line_completes", done_seen && done1_seen, 1'b1);
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        mon_en = 0;

        check("num_reads", got_addr.size(), 3 * NT);
        for (int k = 0; k < 3 * NT && k < got_addr.size(); k++)
            check("read_addr", got_addr[k], exp_addr[k]);
        check("num_pushes", got_pix.size(), NT);
        for (int k = 0; k < NT && k < got_pix.size(); k++)
            check("pix_data", got_pix[k], exp_pix[k]);
        if (v.fixed && got_addr.size() >= 4) begin
            check("first_map_addr", got_addr[0], v.map0);
            check("first_lo_addr", got_addr[1], v.lo0);
            check("first_hi_addr", got_addr[2], v.lo0 + 16'd1);
            check("second_map_addr", got_addr[3], v.map1);
        end
        if (v.has_pix && got_pix.size() > 0) check("first_pix", got_pix[0], v.pix0);
        if (v.cycles != 0) check("line_cycles", done_cyc - first_rd, v.cycles);
        if (v.rm == 2) check("stall_valid_cycles", first_push_len, 6);

        check("l1_reads", reads1, 3 * NT);
        check("l1_line_cycles", done_cyc1 - first_rd1, NT * (3 * L1 + 1));
        check("l1_pushes", got_pix1.size(), NT);
        for (int k = 0; k < NT && k < got_pix1.size(); k++)
            check("l1_pix_data", got_pix1[k], exp_pix[k]);
    endtask

    task automatic reset_mid_line();
        bit reached;
        ly = 0; scx = 0; scy = 0; map_sel = 0; tile_sel = 1;
        clear_mon();
        rmode  = 0;
        mon_en = 1;
        reached = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge clk); #1;
            if (got_addr.size() >= 2) reached = 1;   // LO read under way
        end
        check("reached_lo_read", reached, 1'b1);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check("rst_re_l", re_l, 1'b1);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", addr, 16'h0000);
        check("rst_we_l", we_l, 1'b1);
        @(negedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        mon_en = 1;
        repeat (100) @(negedge clk);
        #1;
        mon_en = 0;
        check("no_read_after_rst", got_addr.size(), 0);
        check("no_push_after_rst", got_pix.size(), 0);
        check("l1_no_push_after_rst", got_pix1.size(), 0);
        check("idle_after_rst", busy, 1'b0);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b1;
        ly = 0; scx = 0; scy = 0; map_sel = 0; tile_sel = 0;
        for (int i = 0; i < 65536; i++) vram[i] = 8'($urandom);
        vram['h9800] = 8'h01;
        vram['h8010] = 8'hAA;
        vram['h8011] = 8'h55;
        vram['h9801] = 8'h80;
        vram['h9802] = 8'h7F;
        vram['h9C1F] = 8'h02;

        //          ly     scx    scy    ms ts rm dbl fix map0      map1      lo0       pix?  pix0      cycles
        tbl[0] = '{8'd0,   8'h00, 8'd0,   0, 1, 0, 0, 1, 16'h9800, 16'h9801, 16'h8010, 1, 16'h55AA, 147};
        tbl[1] = '{8'd3,   8'h08, 8'd0,   0, 0, 0, 1, 1, 16'h9801, 16'h9802, 16'h8806, 0, 16'h0000, 147};
        tbl[2] = '{8'd3,   8'h10, 8'd0,   0, 0, 0, 0, 1, 16'h9802, 16'h9803, 16'h97F6, 0, 16'h0000, 147};
        tbl[3] = '{8'd10,  8'hF8, 8'd250, 1, 1, 0, 0, 1, 16'h9C1F, 16'h9C00, 16'h8028, 0, 16'h0000, 147};
        tbl[4] = '{8'd255, 8'h00, 8'd1,   0, 1, 1, 0, 1, 16'h9800, 16'h9801, 16'h8010, 1, 16'h55AA, 0};
        tbl[5] = '{8'd0,   8'h00, 8'd0,   0, 1, 2, 0, 1, 16'h9800, 16'h9801, 16'h8010, 1, 16'h55AA, 152};

        repeat (3) @(negedge clk);
        check("reset_addr", addr, 16'h0000);
        check("reset_re_l", re_l, 1'b1);
        check("reset_we_l", we_l, 1'b1);
        check("reset_pix", pix, 16'h0000);
        check("reset_valid", valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 6; t++) run_line(tbl[t]);

        reset_mid_line();

        for (int t = 0; t < 4; t++) begin
            rv = tbl[0];
            rv.ly = 8'($urandom); rv.scx = 8'($urandom); rv.scy = 8'($urandom);
            rv.ms = 1'($urandom); rv.ts = 1'($urandom);
            rv.rm = (t == 0) ? 0 : 1;
            rv.fixed = 0; rv.has_pix = 0;
            rv.cycles = (t == 0) ? NT * (3 * L + 1) : 0;
            run_line(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
